// File: rtl/freq_generator_if.sv
`timescale 1ns/1ps
`default_nettype none
// freq_generator_if: load/digit request and status/wave bundle for freq_generator.
// Optional pulse signal present only when FREQGEN_PULSE_EN is defined.
interface freq_generator_if;
  logic       load;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       busy;
  logic       err;
  logic       wave;
`ifdef FREQGEN_PULSE_EN
  logic       pulse;

  modport master (output load, bcd3, bcd2, bcd1, bcd0, input busy, err, wave, pulse);
  modport slave  (input load, bcd3, bcd2, bcd1, bcd0, output busy, err, wave, pulse);
`else
  modport master (output load, bcd3, bcd2, bcd1, bcd0, input busy, err, wave);
  modport slave  (input load, bcd3, bcd2, bcd1, bcd0, output busy, err, wave);
`endif
endinterface
`default_nettype wire

// File: rtl/freq_generator.sv
`timescale 1ns/1ps
`default_nettype none
// freq_generator: BCD-programmed 50% square-wave source (rev 1.0).
// Optional macro FREQGEN_PULSE_EN adds a one-cycle strobe on each wave rising edge.
module freq_generator #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CW     = 26
) (
  input wire logic        clk,
  input wire logic        reset,
  freq_generator_if.slave bus
);
  localparam int            SW         = $clog2(CW + 1);
  localparam logic [CW-1:0] c_half     = CW'(CLK_HZ / 2);
  localparam logic [SW-1:0] c_div_last = SW'(CW - 1);
  localparam logic [SW-1:0] c_cvt_last = SW'(3);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DIVIDE, S_RUN} state_t;

  state_t        r_state;
  logic [15:0]   r_digits;
  logic [SW-1:0] r_step;
  logic [13:0]   r_acc;
  logic [13:0]   r_rem;
  logic [CW-1:0] r_dvd;
  logic [CW-1:0] r_quo;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_err;
  logic          r_wave;
`ifdef FREQGEN_PULSE_EN
  logic          r_pulse;
`endif

  logic          w_bad;
  logic [3:0]    w_digit;
  logic [13:0]   w_acc_next;
  logic [14:0]   w_rem_sh;
  logic          w_ge;
  logic [CW-1:0] w_q_next;
  logic [CW-1:0] w_h_next;
  logic          w_toggle;

  assign w_bad = (bus.bcd3 > 4'd9) || (bus.bcd2 > 4'd9) ||
                 (bus.bcd1 > 4'd9) || (bus.bcd0 > 4'd9);

  always_comb begin
    w_digit = r_digits[3:0];
    case (r_step[1:0])
      2'd0: w_digit = r_digits[15:12];
      2'd1: w_digit = r_digits[11:8];
      2'd2: w_digit = r_digits[7:4];
      2'd3: w_digit = r_digits[3:0];
      default: w_digit = r_digits[3:0];
    endcase
  end

  assign w_acc_next = {r_acc[10:0], 3'b000} + {r_acc[12:0], 1'b0} + {10'd0, w_digit};

  // Remainder stays below f (< 2^14), so one extra bit covers the shifted value.
  assign w_rem_sh = {r_rem, r_dvd[CW-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_acc};
  assign w_q_next = CW'({r_quo, w_ge});
  assign w_h_next = (w_q_next == '0) ? CW'(1) : w_q_next;
  assign w_toggle = (r_h != '0) && (r_cnt == r_h - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_digits <= '0;
      r_step   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_quo    <= '0;
      r_h      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_wave   <= 1'b0;
`ifdef FREQGEN_PULSE_EN
      r_pulse  <= 1'b0;
`endif
    end else begin
      // Wave generator keeps running on the old period while a retune is computed.
      if (w_toggle) begin
        r_wave <= ~r_wave;
        r_cnt  <= '0;
      end else if (r_h != '0) begin
        r_cnt <= r_cnt + CW'(1);
      end
`ifdef FREQGEN_PULSE_EN
      r_pulse <= w_toggle && !r_wave;
`endif

      case (r_state)
        S_IDLE, S_RUN: begin
          if (bus.load) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err    <= 1'b0;
              r_digits <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
              r_acc    <= '0;
              r_step   <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_CONVERT;
            end
          end
        end

        S_CONVERT: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + SW'(1);
          if (r_step == c_cvt_last) begin
            r_step <= '0;
            if (w_acc_next == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_h     <= '0;
              r_cnt   <= '0;
              r_wave  <= 1'b0;
`ifdef FREQGEN_PULSE_EN
              r_pulse <= 1'b0;
`endif
            end else begin
              r_state <= S_DIVIDE;
              r_rem   <= '0;
              r_quo   <= '0;
              r_dvd   <= c_half;
            end
          end
        end

        S_DIVIDE: begin
          r_rem  <= 14'(w_ge ? (w_rem_sh - {1'b0, r_acc}) : w_rem_sh);
          r_quo  <= w_q_next;
          r_dvd  <= r_dvd << 1;
          r_step <= r_step + SW'(1);
          if (r_step == c_div_last) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
            r_h     <= w_h_next;
            r_cnt   <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.err  = r_err;
  assign bus.wave = r_wave;
`ifdef FREQGEN_PULSE_EN
  assign bus.pulse = r_pulse;
`endif
endmodule
`default_nettype wire

// File: tb/tb_freq_generator.sv
`timescale 1ns/1ps
`default_nettype none
// tb_freq_generator: table-driven scoreboard bench for freq_generator at CLK_HZ=1000, CW=10.
module tb_freq_generator;
  localparam int CLK_HZ = 1000;
  localparam int CW     = 10;
  localparam int NV     = 12;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  freq_generator_if bus();

  freq_generator #(.CLK_HZ(CLK_HZ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    bit          err;
    int          h;
    int          busy_n;
  } vec_t;

  typedef struct {
    bit err;
    int h;
    int busy_n;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dig(input logic [15:0] d);
    bus.bcd3 = d[15:12];
    bus.bcd2 = d[11:8];
    bus.bcd1 = d[7:4];
    bus.bcd0 = d[3:0];
  endtask

  task automatic load_digits(input logic [15:0] d);
    set_dig(d);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic measure_half(output int n);
    logic w0;
    w0 = bus.wave;
    n  = 0;
    while (bus.wave === w0 && n < 1200) begin
      tick();
      n++;
    end
    if (n >= 1200) n = -1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

`ifdef FREQGEN_PULSE_EN
  int   n_pulse = 0;
  int   n_rise  = 0;
  logic prev_wave = 1'b0;
  always @(negedge clk) begin
    if (bus.pulse === 1'b1) n_pulse++;
    if (bus.wave === 1'b1 && prev_wave === 1'b0) n_rise++;
    prev_wave = bus.wave;
  end
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n;
    int   bad;

    vecs[0]  = '{dig: 16'h0005, err: 1'b0, h: 100, busy_n: 14};
    vecs[1]  = '{dig: 16'h0001, err: 1'b0, h: 500, busy_n: 14};
    vecs[2]  = '{dig: 16'h9999, err: 1'b0, h: 1,   busy_n: 14};
    vecs[3]  = '{dig: 16'h0000, err: 1'b0, h: 0,   busy_n: 4};
    vecs[4]  = '{dig: 16'h0005, err: 1'b0, h: 100, busy_n: 14};
    vecs[5]  = '{dig: 16'h00A3, err: 1'b1, h: 100, busy_n: 0};
    vecs[6]  = '{dig: 16'h0250, err: 1'b0, h: 2,   busy_n: 14};
    vecs[7]  = '{dig: 16'h1000, err: 1'b0, h: 1,   busy_n: 14};
    vecs[8]  = '{dig: 16'h0500, err: 1'b0, h: 1,   busy_n: 14};
    vecs[9]  = '{dig: 16'h0003, err: 1'b0, h: 166, busy_n: 14};
    vecs[10] = '{dig: 16'h0007, err: 1'b0, h: 71,  busy_n: 14};
    vecs[11] = '{dig: 16'hF000, err: 1'b1, h: 71,  busy_n: 0};

    bus.load = 1'b0;
    set_dig(16'h0000);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    check("reset busy", bus.busy, 0);
    check("reset err", bus.err, 0);
    check("reset wave", bus.wave, 0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.wave !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) bad++;
    end
    check("idle quiet cycles", bad, 0);

    for (int i = 0; i < NV; i++) begin
      sb.push_back('{err: vecs[i].err, h: vecs[i].h, busy_n: vecs[i].busy_n});
      load_digits(vecs[i].dig);
      e = sb.pop_front();
      check($sformatf("v%0d err", i), bus.err, e.err);
      if (e.err) begin
        check($sformatf("v%0d busy", i), bus.busy, 0);
        measure_half(n);
        measure_half(n);
        check($sformatf("v%0d kept half", i), n, e.h);
      end else begin
        wait_idle(n);
        check($sformatf("v%0d busy cycles", i), n, e.busy_n);
        if (e.h == 0) begin
          bad = 0;
          for (int c = 0; c < 20; c++) begin
            if (bus.wave !== 1'b0) bad++;
            tick();
          end
          check($sformatf("v%0d wave held low", i), bad, 0);
        end else begin
          measure_half(n);
          check($sformatf("v%0d first half", i), n, e.h);
          measure_half(n);
          check($sformatf("v%0d second half", i), n, e.h);
        end
      end
    end

    // Retune from a running f=5: old toggle must land inside the busy window.
    load_digits(16'h0005);
    wait_idle(n);
    measure_half(n);
    check("retune base half", n, 100);
    repeat (90) tick();
    load_digits(16'h0001);
    n = 0;
    begin
      logic w0;
      w0 = bus.wave;
      while (bus.wave === w0 && n < 40) begin
        tick();
        n++;
      end
    end
    check("retune old toggle", n, 9);
    check("retune busy at old toggle", bus.busy, 1);
    wait_idle(n);
    measure_half(n);
    check("retune new half 1", n, 500);
    measure_half(n);
    check("retune new half 2", n, 500);

    // Loads during busy are ignored, including invalid digits.
    load_digits(16'h0002);
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      if (n == 5) begin
        set_dig(16'h00A0);
        bus.load = 1'b1;
      end else if (n == 7) begin
        set_dig(16'h0005);
        bus.load = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      if (n == 5) check("busy load no err", bus.err, 0);
    end
    check("busy load cycles", n, 14);
    measure_half(n);
    check("busy load half", n, 250);

    // Reset mid-RUN with err set and wave high.
    load_digits(16'h00A0);
    check("run err set", bus.err, 1);
    n = 0;
    while (bus.wave !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("run reset err", bus.err, 0);
    check("run reset wave", bus.wave, 0);

    // Reset mid-DIVIDE.
    load_digits(16'h0005);
    repeat (7) tick();
    check("divide still busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("divide reset busy", bus.busy, 0);
    check("divide reset wave", bus.wave, 0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.wave !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("post reset quiet", bad, 0);

    // Reset and load together: reset wins.
    set_dig(16'h0005);
    reset    = 1'b1;
    bus.load = 1'b1;
    tick();
    reset    = 1'b0;
    bus.load = 1'b0;
    check("reset vs load busy", bus.busy, 0);
    tick();
    check("reset vs load busy later", bus.busy, 0);

`ifdef FREQGEN_PULSE_EN
    check("pulse count", n_pulse, n_rise);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/freq_generator.md
# freq_generator

Programmable square-wave source for bench and self-test use: the transmit-side counterpart of the frequency counter. It accepts a target frequency as four BCD digits (0–9999 Hz), converts it to binary and computes a half-period count from the system clock. It then drives a 50 %-duty square wave on `wave`, which can loop back into the counter's `eden` input.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `CW`, default 26: half-period counter and quotient width; must satisfy 2^CW > CLK_HZ/2.
- `clk`  in  1: system clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `load`  in  1: single-cycle request to latch `bcd3..bcd0` and retune.
- `bcd3`, `bcd2`, `bcd1`, `bcd0`  in  4 each: target frequency digits, thousands to units.
- `busy`  out  1: conversion in progress; new `load` ignored.
- `err`  out  1: last `load` rejected (a digit > 9); sticky until next accepted `load` or `reset`.
- `wave`  out  1: generated square wave.
- `pulse`  out  1: present only with `FREQGEN_PULSE_EN` (see Configuration).

## Operation
- States: IDLE, CONVERT, DIVIDE, RUN.
- IDLE: `wave` held 0, no period loaded.
- `load` while `busy`=0:
  - Any digit > 9: set `err`=1, keep the current state and period.
  - Otherwise: clear `err`, capture digits, enter CONVERT.
- CONVERT: 4 cycles, Horner accumulation acc = acc*10 + digit, `bcd3` first; 14-bit result f.
- f = 0: skip DIVIDE, go to IDLE with `wave`=0.
- DIVIDE: restoring division of CLK_HZ/2 by f, one quotient bit per cycle, CW cycles, MSB first.
- Half period H = max(1, floor(CLK_HZ/(2*f))).
  - f > CLK_HZ/2 clamps to H=1, so `wave` toggles every clock.
- RUN: counter `cnt` increments each cycle; when `cnt` = H-1, toggle `wave` and clear `cnt`.
- Retune from RUN: old period continues unchanged during CONVERT/DIVIDE.
  - On completion, `cnt` clears, `wave` keeps its current level, and the first toggle comes H cycles later.
  - No runt pulse shorter than min(old H, new H).
- `load` while `busy`=1: ignored, no effect on `err`.

## Timing
- Reset values: `busy`=0, `err`=0, `wave`=0, `pulse`=0, state IDLE, H=0, `cnt`=0.
- `load` sampled at edge k. `busy`=1 after edge k, through the output of edge k+4+CW-1. `busy`=0 after edge k+4+CW, with the new H active from that edge.
  - Default: 30 cycles of `busy`.
- f = 0 path: `busy` high for 4 cycles; `wave` forced 0 at the edge `busy` falls.
- `err` updates at edge k, and `busy` stays 0 for a rejected load.
- Output period = 2*H clocks exactly; duty is 50 %.
- `reset` mid-conversion or mid-RUN aborts everything; all outputs return to reset values on the next edge.
- `reset` and `load` in the same cycle: `reset` wins.

## Configuration
- `FREQGEN_PULSE_EN` defined: output `pulse` is a one-cycle strobe, registered concurrently with each 0→1 transition of `wave`. It gives a clean single-clock event for the counter's `eden` input without edge detection.
- Undefined: port `pulse` and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use bench parameters CLK_HZ=1000, CW=10.
- Reset then idle 100 cycles -> `wave`=0, `busy`=0, `err`=0 throughout.
- `load` with digits 0,0,0,5 (f=5) -> `busy` high 14 cycles; then `wave` toggles every 100 cycles, period 200.
- Running at f=5, `load` digits 0,0,0,1 (f=1) -> old 100-cycle toggles continue during `busy`; then toggles every 500 cycles from the completion edge.
- `load` digits 9,9,9,9 -> H clamped to 1, `wave` alternates every clock; `load` digits 0,0,0,0 -> `wave`=0 after 4 busy cycles.
- `load` digits 0,0,0xA,3 while running at f=5 -> `err`=1 next cycle, `busy` stays 0, period stays 200. A following valid `load` clears `err`.
- `load` re-asserted during `busy`, and `reset` asserted mid-DIVIDE -> second `load` ignored; after reset all outputs return to 0 next cycle. With `FREQGEN_PULSE_EN`, `pulse` count equals the `wave` rising-edge count.
